// File: rtl/seq_divider_if.sv
// Divide handshake between the ALU (master) and the sequential divider (slave).
interface seq_divider_if #(
  parameter int WIDTH = 32
);
  logic               signed_div_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic               start_i;
  logic               annul_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/seq_divider.sv
// Multi-cycle radix-2 restoring divider, signed/unsigned, result {remainder, quotient}.
// Define DIV_ZERO_FLAG_EN to add the div_zero_o status output.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst,
`ifdef DIV_ZERO_FLAG_EN
  output logic          div_zero_o,
`endif
  seq_divider_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, DIVZERO, ON, END} state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem;
  logic             neg_q;
  logic             neg_r;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;

  // dvd starts as the dividend and fills with quotient bits from the right as it shifts out
  always_comb begin
    a_neg   = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
    b_neg   = bus.signed_div_i & bus.opdata2_i[WIDTH-1];
    a_abs   = a_neg ? -bus.opdata1_i : bus.opdata1_i;
    b_abs   = b_neg ? -bus.opdata2_i : bus.opdata2_i;
    shifted = {rem, dvd[WIDTH-1]};
    diff    = shifted - {1'b0, dvs};
    q_fix   = neg_q ? -dvd : dvd;
    r_fix   = neg_r ? -rem : rem;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      dvd          <= '0;
      dvs          <= '0;
      rem          <= '0;
      neg_q        <= 1'b0;
      neg_r        <= 1'b0;
      bus.result_o <= '0;
      bus.ready_o  <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
      div_zero_o   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_i && !bus.annul_i) begin
            dvd   <= a_abs;
            dvs   <= b_abs;
            rem   <= '0;
            cnt   <= '0;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            state <= (bus.opdata2_i == '0) ? DIVZERO : ON;
          end
        end

        DIVZERO: begin
          if (bus.annul_i) begin
            state <= IDLE;
          end else begin
            bus.result_o <= '0;
            bus.ready_o  <= 1'b1;
`ifdef DIV_ZERO_FLAG_EN
            div_zero_o   <= 1'b1;
`endif
            state        <= END;
          end
        end

        ON: begin
          if (bus.annul_i) begin
            state <= IDLE;
          end else if (cnt == CW'(WIDTH)) begin
            bus.result_o <= {r_fix, q_fix};
            bus.ready_o  <= 1'b1;
`ifdef DIV_ZERO_FLAG_EN
            div_zero_o   <= 1'b0;
`endif
            state        <= END;
          end else begin
            // A borrow in the trial subtract means restore: keep the shifted remainder
            rem <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
            dvd <= {dvd[WIDTH-2:0], ~diff[WIDTH]};
            cnt <= cnt + 1'b1;
          end
        end

        END: begin
          if (!bus.start_i || bus.annul_i) begin
            bus.ready_o <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
            div_zero_o  <= 1'b0;
`endif
            state       <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
